// File: rtl/fwd_scoreboard.sv
// Operand-forwarding and load-use hazard unit for the in-order pipeline.
// Tracks producer tags for NUM_STAGES stages after EX and picks the youngest match per operand.
module fwd_scoreboard #(
    parameter int NUM_SRC    = 2,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_READY = 2,
    parameter int REG_AW     = 5,
    parameter int CNT_W      = 16,
    localparam int SELW      = $clog2(NUM_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic                      ex_regwrite,
    input  logic                      ex_is_load,
    input  logic [REG_AW-1:0]         ex_rd,
    input  logic [NUM_SRC*REG_AW-1:0] ex_rs,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      clr_cnt,
    output logic [NUM_SRC*SELW-1:0]   fwd_sel,
    output logic                      load_use_stall,
    output logic [CNT_W-1:0]          stall_cnt
);

    logic [NUM_STAGES:1]             vld_q, vld_d;
    logic [NUM_STAGES:1]             rw_q, rw_d;
    logic [NUM_STAGES:1]             ld_q, ld_d;
    logic [NUM_STAGES:1][REG_AW-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]                stall_cnt_q, stall_cnt_d;

    logic [NUM_SRC*SELW-1:0] sel_c;
    logic                    stall_c;
    logic [REG_AW-1:0]       rs;
    logic                    found;
    logic                    hazard;
    logic [SELW-1:0]         win;

    // The first matching stage in ascending order is the youngest producer; older matches are
    // ignored even when the youngest one is a load that cannot forward yet.
    always_comb begin
        sel_c   = '0;
        stall_c = 1'b0;
        rs      = '0;
        found   = 1'b0;
        hazard  = 1'b0;
        win     = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            rs     = ex_rs[i*REG_AW +: REG_AW];
            found  = 1'b0;
            hazard = 1'b0;
            win    = '0;
            for (int unsigned k = 1; k <= NUM_STAGES; k++) begin
                if (!found && ex_valid && vld_q[k] && rw_q[k] &&
                    (rd_q[k] != '0) && (rd_q[k] == rs)) begin
                    found  = 1'b1;
                    win    = SELW'(k);
                    hazard = ld_q[k] && (k < unsigned'(LOAD_READY));
                end
            end
            sel_c[i*SELW +: SELW] = hazard ? '0 : win;
            stall_c               = stall_c | hazard;
        end
    end

    always_comb begin
        vld_d = vld_q;
        rw_d  = rw_q;
        ld_d  = ld_q;
        rd_d  = rd_q;
        if (!freeze) begin
            for (int unsigned k = 2; k <= NUM_STAGES; k++) begin
                vld_d[k] = vld_q[k-1];
                rw_d[k]  = rw_q[k-1];
                ld_d[k]  = ld_q[k-1];
                rd_d[k]  = rd_q[k-1];
            end
            if (stall_c || flush) begin
                vld_d[1] = 1'b0;
                rw_d[1]  = 1'b0;
                ld_d[1]  = 1'b0;
                rd_d[1]  = '0;
            end else begin
                vld_d[1] = ex_valid;
                rw_d[1]  = ex_regwrite;
                ld_d[1]  = ex_is_load;
                rd_d[1]  = ex_rd;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_cnt) begin
            stall_cnt_d = '0;
        end else if (stall_c && !freeze && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q       <= '0;
            rw_q        <= '0;
            ld_q        <= '0;
            rd_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            vld_q       <= vld_d;
            rw_q        <= rw_d;
            ld_q        <= ld_d;
            rd_q        <= rd_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_sel        = sel_c;
    assign load_use_stall = stall_c;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random traffic
// compared against a queue-based model of the producer history.
module tb_fwd_scoreboard;

    localparam int LOAD_READY = 2;
    localparam int NSTG       = 3;

    typedef struct packed {
        logic       vld;
        logic       rw;
        logic       ld;
        logic [4:0] rd;
    } tag_t;

    logic       clk;
    logic       rst;
    logic       ex_valid, ex_regwrite, ex_is_load;
    logic [4:0] ex_rd, rs0, rs1;
    logic [9:0] ex_rs;
    logic       freeze, flush, clr_cnt;
    logic [3:0] fwd_sel;
    logic       load_use_stall;
    logic [3:0] stall_cnt;

    assign ex_rs = {rs1, rs0};

    fwd_scoreboard #(
        .NUM_SRC(2),
        .NUM_STAGES(NSTG),
        .LOAD_READY(LOAD_READY),
        .REG_AW(5),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ex_valid(ex_valid),
        .ex_regwrite(ex_regwrite),
        .ex_is_load(ex_is_load),
        .ex_rd(ex_rd),
        .ex_rs(ex_rs),
        .freeze(freeze),
        .flush(flush),
        .clr_cnt(clr_cnt),
        .fwd_sel(fwd_sel),
        .load_use_stall(load_use_stall),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    // Model: m[0] is the youngest tracked producer (stage 1).
    tag_t        m[$];
    int unsigned cnt;
    logic [1:0]  exp_sel[2];
    logic        exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m.delete();
        repeat (NSTG) m.push_back('0);
        cnt = 0;
    endtask

    task automatic model_eval();
        logic [4:0] rs;
        exp_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rs = (i == 0) ? rs0 : rs1;
            exp_sel[i] = 2'd0;
            if (ex_valid && rs != 5'd0) begin
                for (int k = 0; k < NSTG; k++) begin
                    if (m[k].vld && m[k].rw && m[k].rd == rs) begin
                        if (m[k].ld && (k + 1) < LOAD_READY) exp_stall = 1'b1;
                        else exp_sel[i] = 2'(k + 1);
                        break;
                    end
                end
            end
        end
    endtask

    task automatic model_step();
        tag_t e;
        if (clr_cnt) cnt = 0;
        else if (exp_stall && !freeze && cnt != 15) cnt++;
        if (!freeze) begin
            if (exp_stall || flush) e = '0;
            else e = {ex_valid, ex_regwrite, ex_is_load, ex_rd};
            m.push_front(e);
            void'(m.pop_back());
        end
    endtask

    // Starts and ends on a falling edge; compares combinational outputs before the rising edge.
    task automatic cycle();
        model_eval();
        #1;
        chk("sel0", 32'(fwd_sel[1:0]), 32'(exp_sel[0]));
        chk("sel1", 32'(fwd_sel[3:2]), 32'(exp_sel[1]));
        chk("stall", 32'(load_use_stall), 32'(exp_stall));
        chk("cnt", 32'(stall_cnt), cnt);
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic expect_now(input string tag, input int s0, input int s1, input int st);
        #1;
        chk({tag, "_sel0"}, 32'(fwd_sel[1:0]), s0);
        chk({tag, "_sel1"}, 32'(fwd_sel[3:2]), s1);
        chk({tag, "_stall"}, 32'(load_use_stall), st);
    endtask

    task automatic drive(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                         input logic [4:0] r0, input logic [4:0] r1);
        ex_valid    = v;
        ex_regwrite = rw;
        ex_is_load  = ld;
        ex_rd       = rd;
        rs0         = r0;
        rs1         = r1;
    endtask

    initial begin
        rst = 1'b0;
        freeze = 1'b0; flush = 1'b0; clr_cnt = 1'b0;
        drive(1, 0, 0, 0, 5, 5);
        model_reset();
        repeat (2) @(negedge clk);
        expect_now("reset", 0, 0, 0);
        chk("reset_cnt", 32'(stall_cnt), 0);
        rst = 1'b1;

        // ALU dependency walking through all three stages
        drive(1, 1, 0, 5, 0, 0); cycle();
        drive(1, 0, 0, 0, 5, 0);
        expect_now("alu_s1", 1, 0, 0); cycle();
        expect_now("alu_s2", 2, 0, 0); cycle();
        expect_now("alu_s3", 3, 0, 0); cycle();
        expect_now("alu_gone", 0, 0, 0); cycle();

        // Two producers of the same register: youngest wins
        drive(1, 1, 0, 7, 0, 0); cycle(); cycle();
        drive(1, 0, 0, 0, 0, 7);
        expect_now("dbl", 0, 1, 0); cycle();

        // Load-use with an older ALU producer of the same register behind it
        drive(1, 1, 0, 9, 0, 0); cycle();
        drive(1, 1, 1, 9, 0, 0); cycle();
        drive(1, 0, 0, 0, 9, 0);
        expect_now("lu_stall", 0, 0, 1); cycle();
        chk("lu_cnt", 32'(stall_cnt), 1);
        expect_now("lu_after", 2, 0, 0); cycle();

        // Freeze during a hazard holds state and counter
        drive(1, 1, 1, 9, 0, 0); cycle();
        drive(1, 0, 0, 0, 9, 0);
        freeze = 1'b1;
        repeat (3) begin
            expect_now("frz_hold", 0, 0, 1); cycle();
        end
        chk("frz_cnt_hold", 32'(stall_cnt), 1);
        freeze = 1'b0;
        expect_now("frz_rel", 0, 0, 1); cycle();
        chk("frz_cnt_inc", 32'(stall_cnt), 2);
        expect_now("frz_after", 2, 0, 0); cycle();

        // Flush kills the EX producer; rd=0 producer never forwards
        flush = 1'b1;
        drive(1, 1, 0, 4, 0, 0); cycle();
        flush = 1'b0;
        drive(1, 0, 0, 0, 4, 4);
        expect_now("flush", 0, 0, 0); cycle();
        drive(1, 1, 0, 0, 0, 0); cycle();
        drive(1, 0, 0, 0, 0, 0);
        expect_now("x0", 0, 0, 0); cycle();

        // ex_valid gates matching
        drive(1, 1, 0, 6, 0, 0); cycle();
        drive(0, 0, 0, 0, 6, 6);
        expect_now("novalid", 0, 0, 0); cycle();

        // Asynchronous reset with all stages valid
        drive(1, 1, 0, 1, 0, 0); cycle();
        drive(1, 1, 0, 2, 0, 0); cycle();
        drive(1, 1, 0, 3, 0, 0); cycle();
        drive(1, 0, 0, 0, 1, 3);
        expect_now("pre_rst", 3, 1, 0);
        #2;
        rst = 1'b0;
        model_reset();
        expect_now("async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        expect_now("rst_first", 0, 0, 0); cycle();

        // Counter saturation then clear winning over increment
        repeat (16) begin
            drive(1, 1, 1, 10, 0, 0); cycle();
            drive(1, 0, 0, 0, 10, 0); cycle();
        end
        chk("sat_cnt", 32'(stall_cnt), 15);
        drive(1, 1, 1, 10, 0, 0); cycle();
        drive(1, 0, 0, 0, 10, 0);
        clr_cnt = 1'b1;
        expect_now("clr_stall", 0, 0, 1); cycle();
        clr_cnt = 1'b0;
        chk("clr_cnt", 32'(stall_cnt), 0);

        // Random traffic
        repeat (400) begin
            drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            freeze  = ($urandom_range(0, 9) < 2);
            flush   = ($urandom_range(0, 9) < 1);
            clr_cnt = ($urandom_range(0, 19) < 1);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised operand-forwarding and load-use hazard unit for the in-order RISC-V pipeline.
- Keeps its own shift register of producer tags (rd, regwrite, is_load) for NUM_STAGES stages after EX. The pipeline no longer feeds EX/MEM, MEM/WB and WB tags separately.
- For each of NUM_SRC EX-stage source operands it outputs a forward select and a load-use stall request, and counts stall cycles.

Parameters:
- NUM_SRC, 2, number of source operands checked for the EX instruction.
- NUM_STAGES, 3, producer stages tracked after EX (1=EX/MEM, 2=MEM/WB, 3=WB write cycle).
- LOAD_READY, 2, first stage index at which load data is forwardable (1 ≤ LOAD_READY ≤ NUM_STAGES).
- REG_AW, 5, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- ex_valid  input  1  EX holds a real instruction.
- ex_regwrite  input  1  EX instruction writes rd.
- ex_is_load  input  1  EX instruction is a load.
- ex_rd  input  REG_AW  EX destination register.
- ex_rs  input  NUM_SRC*REG_AW  EX source registers; operand i is at [i*REG_AW +: REG_AW].
- freeze  input  1  global pipeline freeze (memory wait).
- flush  input  1  kill the EX instruction (branch taken).
- clr_cnt  input  1  synchronous clear of stall_cnt.
- fwd_sel  output  NUM_SRC*SELW  per-operand select, SELW = $clog2(NUM_STAGES+1). 0 = regfile, k = stage k.
- load_use_stall  output  1  hold EX for one cycle, insert bubble.
- stall_cnt  output  CNT_W  saturating count of load-use stall cycles.

Behaviour:
- State: per stage k (1..NUM_STAGES) holds vld[k], rw[k], ld[k], rd[k].
- Reset (rst=0, async): all vld=0 and stall_cnt=0. Consequently fwd_sel=0 and load_use_stall=0.
- Match, operand i vs stage k: vld[k] && rw[k] && rd[k]!=0 && rd[k]==rs_i, and ex_valid=1.
- Selection: the youngest (lowest k) matching stage wins. fwd_sel_i = k. If no stage matches, fwd_sel_i = 0.
- Register x0: rs_i=0 never matches; fwd_sel_i=0.
- Load-use hazard for operand i: the winning stage k has ld[k]=1 and k<LOAD_READY.
  - Forces fwd_sel_i=0. An older non-load match must not be used.
  - load_use_stall = OR of hazards over all operands, gated by ex_valid.
- fwd_sel and load_use_stall are combinational from state plus EX inputs, with zero latency.
- Update on clk rising edge, in priority order:
  - freeze=1: no stage changes; flush and load_use_stall are ignored for the update.
  - load_use_stall=1: stage1 becomes a bubble (vld=0). Stages k≥2 take stage k-1. EX is held by the pipeline, not by this block.
  - flush=1 (no stall): stage1 becomes a bubble. Stages k≥2 shift.
  - Otherwise: stage1 takes {ex_valid, ex_regwrite, ex_is_load, ex_rd}. Stages k≥2 shift.
  - The last stage's contents are discarded on shift; it represents the regfile write cycle.
- stall_cnt:
  - +1 on each edge with load_use_stall=1 and freeze=0.
  - Saturates at 2^CNT_W-1 with no wrap.
  - clr_cnt=1 sets it to 0 and wins over increment.
- Reset mid-operation: all in-flight tags are dropped immediately. No forwarding occurs on the first cycle after release.

Test Plan:
- Back-to-back ALU dependency: issue rd=5 (regwrite, non-load), then EX rs1=5, rs2=0 -> fwd_sel op0=1, op1=0, stall=0. With no further match, next cycle op0=2, then 3, then 0.
- Double producer: stage1 rd=7 and stage2 rd=7 both regwrite, EX rs2=7 -> op1 sel=1 (youngest wins).
- Load-use: issue load rd=9, then EX rs1=9 -> load_use_stall=1, op0 sel=0, stall_cnt 0->1. Next cycle the load is in stage2 with a bubble in stage1 -> stall=0, op0 sel=2.
- Freeze during hazard: load in stage1 matching rs1, freeze=1 for 3 cycles -> stall held at 1, stages unchanged, stall_cnt unchanged. Release -> bubble inserted, stall_cnt increments by 1.
- Flush and x0: flush=1 with EX rd=4 -> stage1 vld=0, and a later rs=4 gets sel=0. A producer writing rd=0 never forwards.
- Async reset mid-stream: drop rst while stage1..3 are valid -> all fwd_sel=0 and stall=0 immediately without a clock. Counter saturation: preload near max with CNT_W=4 -> holds 15 under continued stalls; clr_cnt -> 0.
